// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready, holds the one-hot
// line for PULSE_LEN cycles, then one idle gap cycle with a done strobe.
//
// state | meaning
// IDLE  | waiting for a code, in_ready high
// DRIVE | holding the decoded pattern while the down-counter runs to zero
// GAP   | one mandatory idle cycle after a pulse, done asserted
module decoder_3to8_seq #(
    parameter int PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    input  logic       in_zero,
    input  logic       abort,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       done,
    output logic       busy
);

    localparam int CW = $clog2(PULSE_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    out_nxt;
    logic          out_valid_nxt;
    logic          done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
        end
    end

    // abort outranks the terminal count, so an aborted pulse never strobes done
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                if (in_valid) begin
                    out_nxt       = in_zero ? 8'h00 : (8'h01 << in_code);
                    out_valid_nxt = 1'b1;
                    cnt_nxt       = CW'(PULSE_LEN - 1);
                    state_nxt     = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    out_nxt       = 8'h00;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    out_nxt       = 8'h00;
                    out_valid_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    state_nxt     = GAP;
                end
            end
            GAP: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            default: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: two instances (PULSE_LEN 4 and 1) share stimulus
// and are checked every cycle against a per-transaction timeline model.
module tb_decoder_3to8_seq;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_zero, abort;
    logic [2:0] in_code;
    logic [7:0] out_a, out_b;
    logic       ov_a, ov_b, done_a, done_b, rdy_a, rdy_b, busy_a, busy_b;

    always #5 clk = ~clk;

    decoder_3to8_seq #(.PULSE_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_zero(in_zero), .abort(abort), .in_ready(rdy_a), .out(out_a),
        .out_valid(ov_a), .done(done_a), .busy(busy_a)
    );

    decoder_3to8_seq #(.PULSE_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_zero(in_zero), .abort(abort), .in_ready(rdy_b), .out(out_b),
        .out_valid(ov_b), .done(done_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: one transaction accepted at cycle m_tacc drives its pattern for
    // cycles tacc..tacc+P-1, strobes done at tacc+P, is ready at tacc+P+1.
    int         plen   [2] = '{4, 1};
    bit         m_act  [2];
    int         m_tacc [2];
    logic [7:0] m_pat  [2];

    bit         track_done = 1'b0;
    int         done_times[$];

    function automatic bit m_ready(int d, int k);
        return !m_act[d] || (k >= m_tacc[d] + plen[d] + 1);
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] e_out, o_out;
        logic       e_ov, e_done, e_rdy;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0;
            end else if (m_ready(d, cyc - 1)) begin
                if (in_valid) begin
                    m_act[d]  = 1'b1;
                    m_tacc[d] = cyc;
                    m_pat[d]  = in_zero ? 8'h00 : (8'd1 << in_code);
                end
            end else if (abort) begin
                m_act[d] = 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e_ov   = m_act[d] && (cyc >= m_tacc[d]) && (cyc <= m_tacc[d] + plen[d] - 1);
            e_out  = e_ov ? m_pat[d] : 8'h00;
            e_done = m_act[d] && (cyc == m_tacc[d] + plen[d]);
            e_rdy  = m_ready(d, cyc);
            o_out  = (d == 0) ? out_a : out_b;
            chk($sformatf("out[P=%0d]@%0d", plen[d], cyc), o_out, e_out);
            chk($sformatf("out_valid[P=%0d]@%0d", plen[d], cyc), 8'((d == 0) ? ov_a : ov_b), 8'(e_ov));
            chk($sformatf("done[P=%0d]@%0d", plen[d], cyc), 8'((d == 0) ? done_a : done_b), 8'(e_done));
            chk($sformatf("in_ready[P=%0d]@%0d", plen[d], cyc), 8'((d == 0) ? rdy_a : rdy_b), 8'(e_rdy));
            chk($sformatf("busy[P=%0d]@%0d", plen[d], cyc), 8'((d == 0) ? busy_a : busy_b), 8'(!e_rdy));
            chk($sformatf("onehot[P=%0d]@%0d", plen[d], cyc), o_out & (o_out - 8'd1), 8'h00);
        end
        if (track_done && done_a === 1'b1) done_times.push_back(cyc);
    endtask

    initial begin
        int c;
        rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_zero = 1'b0; abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_tacc[d] = 0; m_pat[d] = 8'h00;
        end
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        // codes 0..7 back to back with in_valid held high
        track_done = 1'b1;
        c = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && c < 8; i++) begin
            in_code = 3'(c);
            step();
            if (m_act[0] && m_tacc[0] == cyc) c++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        track_done = 1'b0;
        chk("done_pulse_count", 8'(done_times.size()), 8'd8);
        for (int i = 1; i < done_times.size(); i++)
            chk($sformatf("done_spacing_%0d", i), 8'(done_times[i] - done_times[i-1]), 8'd6);

        // in_zero: empty pattern with normal timing
        in_valid = 1'b1; in_zero = 1'b1; in_code = 3'b101;
        step();
        in_valid = 1'b0; in_zero = 1'b0;
        for (int i = 0; i < 7; i++) step();

        // in_code changed after accept must not disturb the held pattern
        in_valid = 1'b1; in_code = 3'd6;
        step();
        in_valid = 1'b0; in_code = 3'd2;
        for (int i = 0; i < 7; i++) step();

        // abort in the 2nd DRIVE cycle
        in_valid = 1'b1; in_code = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_out", out_a, 8'h00);
        chk("abort_ready", 8'(rdy_a), 8'd1);
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_done", 8'(done_a), 8'd0);

        // reset mid-DRIVE, then immediate new accept
        in_valid = 1'b1; in_code = 3'd7;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1; abort = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0;
        chk("rst_out", out_a, 8'h00);
        chk("rst_ready", 8'(rdy_a), 8'd1);
        in_code = 3'd1;
        step();
        chk("post_rst_accept", out_a, 8'h02);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 3) != 0;
            in_code  = 3'($urandom % 8);
            in_zero  = ($urandom % 5) == 0;
            abort    = ($urandom % 12) == 0;
            rst      = ($urandom % 60) == 0;
            step();
        end
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_seq.md
# decoder_3to8_seq

Sequenced 3-to-8 decoder, the inverse of the 8-to-3 priority encoder in the Day-11 set. It accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then inserts a one-cycle idle gap and signals completion. It sits between a code source (for example, an encoder output or a command register) and eight one-hot strobe consumers.

## Interface
- PULSE_LEN, 4, cycles each one-hot pattern is held; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  code available
- in_code  input  3  binary code; bit index of the line to assert
- in_zero  input  1  "no input" marker, the encoder's all-zero case; when set, out stays 8'h00 for the pulse
- in_ready  output  1  block can accept a code
- abort  input  1  cancel the current pulse
- out  output  8  one-hot decode; 8'h00 when not driving
- out_valid  output  1  out is holding a decoded pattern
- done  output  1  one-cycle pulse when a pulse completes normally
- busy  output  1  state is not IDLE

## Operation
- FSM states are IDLE, DRIVE and GAP.
- IDLE: in_ready=1, out=8'h00, out_valid=0.
  - Accept occurs when in_valid && in_ready at a clock edge.
  - On accept: out <= in_zero ? 8'h00 : (8'h01 << in_code); out_valid <= 1; cnt <= PULSE_LEN-1; go to DRIVE.
  - in_code is sampled only on the accept edge. Later changes to it do not affect out.
- DRIVE: in_ready=0 and out is held.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: out <= 0, out_valid <= 0, done <= 1, go to GAP.
- GAP: out=0, in_ready=0. Go to IDLE unconditionally on the next edge. Every code therefore yields one idle cycle before the next code.
- abort is sampled in DRIVE or GAP and takes priority over the count.
  - Next edge: go to IDLE with out=0, out_valid=0, done=0.
  - No done pulse is generated for an aborted transaction.
  - abort in IDLE is ignored. If abort and in_valid are both high in IDLE, the code is accepted.
- in_zero and in_code are independent. With in_zero=1, in_code is ignored, but out_valid and the timing are identical to a normal code.
- The counter width is $clog2(PULSE_LEN)+1 bits. The counter never wraps: decrement happens only when cnt != 0.
- With PULSE_LEN=1, DRIVE lasts exactly one cycle.

## Timing
- Reset values: out=8'h00, out_valid=0, done=0, busy=0, in_ready=1, cnt=0, state=IDLE.
- All outputs are registered. in_ready and busy are decoded from the state register only, with no combinational path from any input.
- With accept at edge T:
  - out and out_valid are asserted from T+1 through T+PULSE_LEN.
  - done=1 for exactly one cycle, starting at edge T+PULSE_LEN+1.
  - in_ready=1 again from edge T+PULSE_LEN+2.
  - Maximum throughput is one code per PULSE_LEN+2 cycles.
- out is always exactly one-hot or all-zero; it is never multi-hot.
- rst asserted mid-DRIVE returns the block to reset values on that edge, with no done pulse. rst overrides abort and in_valid.

## Test plan
- Reset, then codes 0..7 with in_valid held high (PULSE_LEN=4):
  - out steps 01, 02, 04, 08, 10, 20, 40, 80.
  - Each pattern lasts 4 cycles, followed by a 1-cycle 00 gap.
  - Eight done pulses, spaced 6 cycles apart.
- in_zero=1, in_code=3'b101 -> out=00 for 4 cycles, out_valid=1 for 4 cycles, then done=1 once.
- Accept code 6; change in_code to 2 on the next cycle -> out stays 8'h40 for the full pulse. in_ready stays 0 until 6 cycles after accept.
- Accept code 3; assert abort in the 2nd DRIVE cycle -> out=00 and in_ready=1 on the next edge, and no done pulse.
- Accept code 7; assert rst in DRIVE -> all outputs take reset values on that edge, done stays 0, and a new code is accepted on the next cycle.
- PULSE_LEN=1, code 0 -> out=01 for exactly 1 cycle, done the following cycle, in_ready 3 cycles after accept.
